// File: rtl/mdu_pkg.sv
// Shared types and op-decode helpers for the execute-stage multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  function automatic logic is_div_op(input mdu_op_e op);
    return op[2];
  endfunction

  // Signedness of the divide family only; multiplies decode their own operand signs.
  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/execute_mdu_if.sv
// EX-stage request / EX-MEM result bundle between the pipeline (master) and the MDU (slave).
interface execute_mdu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      valid_e_i;
  logic [2:0]                op_e_i;
  logic [DATA_WIDTH-1:0]     rs1_data_e_i;
  logic [DATA_WIDTH-1:0]     rs2_data_e_i;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_e_i;
  logic                      flush_e_i;
  logic                      stall_e_o;
  logic                      result_valid_m_o;
  logic [DATA_WIDTH-1:0]     result_m_o;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_m_o;

  modport master (
    output valid_e_i, op_e_i, rs1_data_e_i, rs2_data_e_i, rd_addr_e_i, flush_e_i,
    input  stall_e_o, result_valid_m_o, result_m_o, rd_addr_m_o
  );

  modport slave (
    input  valid_e_i, op_e_i, rs1_data_e_i, rs2_data_e_i, rd_addr_e_i, flush_e_i,
    output stall_e_o, result_valid_m_o, result_m_o, rd_addr_m_o
  );
endinterface

// File: rtl/mdu_divider.sv
// Iterative radix-2 restoring divider: DATA_WIDTH iteration cycles, then one sign-fix cycle.
// o_last marks the final iteration, o_done the fix cycle; quotient/remainder are valid afterwards.
module mdu_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_signed,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic                  o_busy,
  output logic                  o_last,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_quot,
  output logic [DATA_WIDTH-1:0] o_rem
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic          r_run;
  logic          r_fix;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_dvs;
  logic          r_neg_q;
  logic          r_neg_r;

  logic [W:0]    w_rem_sh;
  logic [W:0]    w_diff;
  logic          w_ge;
  logic          w_a_neg;
  logic          w_b_neg;

  // Quotient register doubles as the dividend shifter: its MSB feeds the partial remainder.
  assign w_rem_sh = {r_rem, r_quot[W-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[W];
  assign w_a_neg  = i_signed & i_dividend[W-1];
  assign w_b_neg  = i_signed & i_divisor[W-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run   <= 1'b0;
      r_fix   <= 1'b0;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (i_abort) begin
      r_run <= 1'b0;
      r_fix <= 1'b0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_run   <= 1'b1;
      r_fix   <= 1'b0;
      r_cnt   <= '0;
      r_quot  <= w_a_neg ? -i_dividend : i_dividend;
      r_dvs   <= w_b_neg ? -i_divisor : i_divisor;
      r_rem   <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (r_run) begin
      r_rem  <= w_ge ? w_diff[W-1:0] : w_rem_sh[W-1:0];
      r_quot <= {r_quot[W-2:0], w_ge};
      r_cnt  <= r_cnt + 1'b1;
      if (r_cnt == LAST) begin
        r_run <= 1'b0;
        r_fix <= 1'b1;
      end
    end else if (r_fix) begin
      r_quot <= r_neg_q ? -r_quot : r_quot;
      r_rem  <= r_neg_r ? -r_rem : r_rem;
      r_fix  <= 1'b0;
    end
  end

  assign o_busy = r_run | r_fix;
  assign o_last = r_run & (r_cnt == LAST);
  assign o_done = r_fix;
  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/execute_mdu.sv
// RV32M/RV64M execute-stage multiply/divide unit: stalls EX while a multi-cycle op runs,
// then pulses the result into EX/MEM. Multiply is a MUL_STAGES-deep pipeline; divide is iterative.
module execute_mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_STAGES     = 2
) (
  input  logic         clk,
  input  logic         rst,
  execute_mdu_if.slave mdu
);
  localparam int W   = DATA_WIDTH;
  localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_STAGES - 1);

  mdu_state_e                r_state;
  mdu_state_e                w_next_state;
  mdu_op_e                   r_op;
  logic [W-1:0]              r_a;
  logic [W-1:0]              r_b;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic                      r_special;
  logic [W-1:0]              r_spec_res;
  logic [MCW-1:0]            r_mul_cnt;
  logic [2*W-1:0]            r_mul_pipe [MUL_STAGES];
  logic [W-1:0]              r_result;
  logic [REG_ADDR_WIDTH-1:0] r_rd_out;
  logic                      r_res_vld;

  mdu_op_e        w_op_in;
  logic           w_accept;
  logic           w_div_zero;
  logic           w_div_ovf;
  logic           w_special;
  logic [W-1:0]   w_spec_res;
  logic           w_div_start;
  logic           w_div_busy;
  logic           w_div_last;
  logic           w_div_done;
  logic [W-1:0]   w_div_quot;
  logic [W-1:0]   w_div_rem;
  logic           w_a_sx;
  logic           w_b_sx;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_out;
  logic [W-1:0]   w_final;

  assign w_op_in    = mdu_op_e'(mdu.op_e_i);
  assign w_accept   = (r_state == ST_IDLE) & mdu.valid_e_i & ~mdu.flush_e_i;
  assign w_div_zero = (mdu.rs2_data_e_i == '0);
  assign w_div_ovf  = is_signed_op(w_op_in) & (mdu.rs1_data_e_i == {1'b1, {(W-1){1'b0}}})
                    & (mdu.rs2_data_e_i == '1);
  assign w_special  = is_div_op(w_op_in) & (w_div_zero | w_div_ovf);
  // op[1] selects the remainder within the divide family.
  assign w_spec_res = w_op_in[1] ? (w_div_zero ? mdu.rs1_data_e_i : '0)
                                 : (w_div_zero ? '1 : mdu.rs1_data_e_i);
  assign w_div_start = w_accept & is_div_op(w_op_in) & ~w_special;

  mdu_divider #(.DATA_WIDTH(W)) u_divider (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_abort    (mdu.flush_e_i),
    .i_signed   (is_signed_op(w_op_in)),
    .i_dividend (mdu.rs1_data_e_i),
    .i_divisor  (mdu.rs2_data_e_i),
    .o_busy     (w_div_busy),
    .o_last     (w_div_last),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot),
    .o_rem      (w_div_rem)
  );

  // Sign-extend to 2W and take the product modulo 2^2W: correct for all four operand signednesses.
  assign w_a_sx = ((r_op == OP_MULH) | (r_op == OP_MULHSU)) & r_a[W-1];
  assign w_b_sx = (r_op == OP_MULH) & r_b[W-1];
  assign w_prod = {{W{w_a_sx}}, r_a} * {{W{w_b_sx}}, r_b};
  assign w_prod_out = r_mul_pipe[MUL_STAGES-1];

  assign w_final = r_special      ? r_spec_res :
                   is_div_op(r_op) ? (r_op[1] ? w_div_rem : w_div_quot) :
                   (r_op == OP_MUL) ? w_prod_out[W-1:0] : w_prod_out[2*W-1:W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (mdu.valid_e_i) begin
          if (!is_div_op(w_op_in)) w_next_state = ST_MUL;
          else if (w_special)      w_next_state = ST_DONE;
          else                     w_next_state = ST_DIV;
        end
      end
      ST_MUL:  if (r_mul_cnt == MUL_LAST) w_next_state = ST_DONE;
      ST_DIV: begin
        if (w_div_last)       w_next_state = ST_FIX;
        else if (!w_div_busy) w_next_state = ST_IDLE;
      end
      ST_FIX:  w_next_state = w_div_done ? ST_DONE : ST_IDLE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
    if (mdu.flush_e_i) w_next_state = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= OP_MUL;
      r_a        <= '0;
      r_b        <= '0;
      r_rd       <= '0;
      r_special  <= 1'b0;
      r_spec_res <= '0;
      r_mul_cnt  <= '0;
      r_result   <= '0;
      r_rd_out   <= '0;
      r_res_vld  <= 1'b0;
      for (int i = 0; i < MUL_STAGES; i++) r_mul_pipe[i] <= '0;
    end else begin
      r_res_vld     <= 1'b0;
      r_mul_pipe[0] <= w_prod;
      for (int i = 1; i < MUL_STAGES; i++) r_mul_pipe[i] <= r_mul_pipe[i-1];
      if (w_accept) begin
        r_op       <= w_op_in;
        r_a        <= mdu.rs1_data_e_i;
        r_b        <= mdu.rs2_data_e_i;
        r_rd       <= mdu.rd_addr_e_i;
        r_special  <= w_special;
        r_spec_res <= w_spec_res;
        r_mul_cnt  <= '0;
      end else if (r_state == ST_MUL) begin
        r_mul_cnt <= r_mul_cnt + 1'b1;
      end
      if ((r_state == ST_DONE) && !mdu.flush_e_i) begin
        r_result  <= w_final;
        r_rd_out  <= r_rd;
        r_res_vld <= 1'b1;
      end
    end
  end

  assign mdu.stall_e_o        = mdu.valid_e_i & (r_state != ST_DONE) & ~mdu.flush_e_i & ~rst;
  assign mdu.result_valid_m_o = r_res_vld;
  assign mdu.result_m_o       = r_result;
  assign mdu.rd_addr_m_o      = r_rd_out;

endmodule

// File: tb/tb_execute_mdu.sv
// Scoreboarded bench for execute_mdu (DATA_WIDTH=32, MUL_STAGES=2): results, rd, pulse cycle and stall length.
module tb_execute_mdu;
  localparam int MUL_STAGES = 2;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  sb_t  exp_q[$];
  sb_t  mon_e;
  logic [31:0] last_res = '0;

  execute_mdu_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) mdu_bus ();

  execute_mdu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MUL_STAGES(MUL_STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mdu_bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint          ub = longint'({32'b0, b});
    longint unsigned ua = a;
    longint unsigned uu = b;
    logic [63:0]     p;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * uu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / uu; return p[31:0]; end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin if (b == 0) return a; p = ua % uu; return p[31:0]; end
    endcase
  endfunction

  function automatic int stall_len(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_STAGES + 1;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 32 + 2;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that ends DONE with valid still high.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int exp_stall);
    int n;
    mdu_bus.valid_e_i    = 1'b1;
    mdu_bus.op_e_i       = op;
    mdu_bus.rs1_data_e_i = a;
    mdu_bus.rs2_data_e_i = b;
    mdu_bus.rd_addr_e_i  = rd;
    exp_q.push_back('{res: exp, rd: rd, cyc: cyc + exp_stall + 1});
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (mdu_bus.stall_e_o) n++;
      else break;
    end
    check("stall_len", 64'(n), 64'(exp_stall));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    mdu_bus.valid_e_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && mdu_bus.result_valid_m_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'(mdu_bus.result_m_o), 64'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", 64'(mdu_bus.result_m_o), 64'(mon_e.res));
        check("rd", 64'(mdu_bus.rd_addr_m_o), 64'(mon_e.rd));
        check("pulse_cycle", 64'(cyc), 64'(mon_e.cyc));
        last_res = mon_e.res;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    mdu_bus.valid_e_i    = 1'b0;
    mdu_bus.op_e_i       = '0;
    mdu_bus.rs1_data_e_i = '0;
    mdu_bus.rs2_data_e_i = '0;
    mdu_bus.rd_addr_e_i  = '0;
    mdu_bus.flush_e_i    = 1'b0;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 64'(mdu_bus.stall_e_o), 64'h0);
    check("rst_vld", 64'(mdu_bus.result_valid_m_o), 64'h0);
    check("rst_result", 64'(mdu_bus.result_m_o), 64'h0);
    check("rst_rd", 64'(mdu_bus.rd_addr_m_o), 64'h0);
    @(posedge clk); #1;

    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB, 3);
    idle(2);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFE, 3);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'h0000_0000, 3);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFF, 3);
    idle(2);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD, 34);
    idle(2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF, 34);
    idle(2);
    issue(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1);
    issue(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1);
    idle(2);

    // Flush in cycle 10 of a divide, then a multiply the next cycle.
    mdu_bus.valid_e_i    = 1'b1;
    mdu_bus.op_e_i       = 3'd4;
    mdu_bus.rs1_data_e_i = 32'd1000;
    mdu_bus.rs2_data_e_i = 32'd7;
    mdu_bus.rd_addr_e_i  = 5'd13;
    repeat (10) @(posedge clk);
    #1 mdu_bus.flush_e_i = 1'b1;
    @(negedge clk);
    check("flush_stall", 64'(mdu_bus.stall_e_o), 64'h0);
    check("flush_hold", 64'(mdu_bus.result_m_o), 64'(last_res));
    @(posedge clk); #1;
    mdu_bus.flush_e_i = 1'b0;
    issue(3'd0, 32'd12, 32'd11, 5'd14, 32'd132, 3);
    idle(2);

    // Reset in cycle 5 of a divide, with valid still asserted.
    mdu_bus.valid_e_i    = 1'b1;
    mdu_bus.op_e_i       = 3'd5;
    mdu_bus.rs1_data_e_i = 32'd99;
    mdu_bus.rs2_data_e_i = 32'd3;
    mdu_bus.rd_addr_e_i  = 5'd15;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_stall", 64'(mdu_bus.stall_e_o), 64'h0);
    check("midrst_vld", 64'(mdu_bus.result_valid_m_o), 64'h0);
    check("midrst_result", 64'(mdu_bus.result_m_o), 64'h0);
    check("midrst_rd", 64'(mdu_bus.rd_addr_m_o), 64'h0);
    @(posedge clk); #1;
    mdu_bus.valid_e_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(3'd0, 32'd3, 32'd5, 5'd16, 32'd15, 3);
    // Back-to-back: second op enters EX in the cycle of the first result pulse.
    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd17, 32'hFFFF_FFFE, 3);
    idle(2);

    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 6 == 5) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
      rd = 5'($urandom_range(1, 31));
      issue(op, a, b, rd, model(op, a, b), stall_len(op, a, b));
      if (i % 4 == 3) idle(1);
    end
    idle(4);
    check("sb_drain", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
